// File: rtl/fracnet_acc_requant_if.sv
// fracnet_acc_requant_if: product-in / quantized-result-out stream bundle.
// master drives products, shift and result ready; slave is the requant block.
interface fracnet_acc_requant_if #(
  parameter int PROD_W = 44,
  parameter int OUT_W = 16,
  parameter int SHIFT_W = 6
);
  logic signed [PROD_W-1:0] prod_tdata;
  logic prod_tvalid;
  logic prod_tlast;
  logic prod_tready;
  logic [SHIFT_W-1:0] cfg_shift;
  logic signed [OUT_W-1:0] out_tdata;
  logic out_tvalid;
  logic out_sat;
  logic out_tready;
  logic acc_ovf;
  modport master (
    output prod_tdata, prod_tvalid, prod_tlast, cfg_shift, out_tready,
    input prod_tready, out_tdata, out_tvalid, out_sat, acc_ovf
  );
  modport slave (
    input prod_tdata, prod_tvalid, prod_tlast, cfg_shift, out_tready,
    output prod_tready, out_tdata, out_tvalid, out_sat, acc_ovf
  );
endinterface

// File: rtl/fracnet_acc_requant.sv
// fracnet_acc_requant: accumulate signed product groups, then round-half-up shift and saturate to OUT_W.
// Define FRACNET_ACC_RELU_EN to clamp negative results to zero.
module fracnet_acc_requant #(
  parameter int PROD_W = 44,
  parameter int ACC_W = 52,
  parameter int OUT_W = 16,
  parameter int SHIFT_W = 6
) (
  input logic ap_clk,
  input logic ap_rst_n,
  fracnet_acc_requant_if.slave bus
);
  localparam int CNT_W = ACC_W - PROD_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << (ACC_W - PROD_W);
  localparam logic [SHIFT_W-1:0] SH_RND_MAX = SHIFT_W'(ACC_W);
  localparam logic signed [ACC_W:0] ONE = 1;
  localparam logic signed [ACC_W:0] MAXV = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [ACC_W:0] MINV = -(2 ** (OUT_W - 1));
  typedef enum logic [1:0] {ACC, ROUND, OUT} state_t;
  state_t state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic signed [OUT_W-1:0] data_q, data_d;
  logic ready_q, ready_d, valid_q, valid_d, sat_q, sat_d, ovf_q, ovf_d;
  logic signed [ACC_W:0] rnd, shifted;
  logic accept, first, hi, lo;
  always_comb begin
    accept = ready_q && bus.prod_tvalid;
    first = cnt_q == '0;
    // Rounding term only exists up to shift == ACC_W; beyond that the result is pure sign.
    rnd = (shift_q != '0 && shift_q <= SH_RND_MAX) ? ONE << (shift_q - SHIFT_W'(1)) : '0;
    shifted = ($signed({acc_q[ACC_W-1], acc_q}) + rnd) >>> shift_q;
    hi = shifted > MAXV;
    lo = shifted < MINV;
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    data_d = data_q;
    sat_d = sat_q;
    valid_d = valid_q;
    ovf_d = ovf_q;
    if (state_q == ACC && accept) begin
      acc_d = (first ? '0 : acc_q) + {{(ACC_W - PROD_W){bus.prod_tdata[PROD_W-1]}}, bus.prod_tdata};
      cnt_d = cnt_q + CNT_W'(cnt_q != CNT_MAX);
      shift_d = first ? bus.cfg_shift : shift_q;
      ovf_d = ovf_q | (cnt_q == CNT_MAX && !bus.prod_tlast);
      state_d = bus.prod_tlast ? ROUND : ACC;
    end
    if (state_q == ROUND) begin
`ifdef FRACNET_ACC_RELU_EN
      data_d = shifted[ACC_W] ? '0 : hi ? MAXV[OUT_W-1:0] : shifted[OUT_W-1:0];
      sat_d = hi;
`else
      data_d = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : shifted[OUT_W-1:0];
      sat_d = hi | lo;
`endif
      valid_d = 1'b1;
      state_d = OUT;
    end
    if (state_q == OUT && bus.out_tready) begin
      valid_d = 1'b0;
      cnt_d = '0;
      state_d = ACC;
    end
    ready_d = state_d == ACC;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ACC;
      acc_q <= '0;
      cnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      sat_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      sat_q <= sat_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.prod_tready = ready_q;
  assign bus.out_tdata = data_q;
  assign bus.out_tvalid = valid_q;
  assign bus.out_sat = sat_q;
  assign bus.acc_ovf = ovf_q;
endmodule

// File: tb/tb_fracnet_acc_requant.sv
// tb_fracnet_acc_requant: vector table, directed corner sequences and randomized groups
// checked against an arithmetic reference model of the requantizer.
module tb_fracnet_acc_requant;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  fracnet_acc_requant_if bus ();
  fracnet_acc_requant dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));
  always #5 ap_clk = ~ap_clk;
  typedef struct {
    longint d;
    int sh;
    longint exp;
    bit sat;
  } vec_t;
  vec_t vecs[$];
  longint beats[$];
  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask
  function automatic void relu_adj(inout longint e, inout bit s);
`ifdef FRACNET_ACC_RELU_EN
    if (e < 0) begin
      e = 0;
      s = 0;
    end
`endif
  endfunction
  function automatic void model(input longint acc_in, input int sh, output longint r, output bit sat);
    longint acc, v;
    bit hi, lo;
    acc = (acc_in <<< 12) >>> 12;
    if (sh == 0) v = acc;
    else if (sh <= 52) v = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    else v = acc < 0 ? -1 : 0;
    hi = v > 32767;
    lo = v < -32768;
    r = hi ? 32767 : lo ? -32768 : v;
    sat = hi | lo;
`ifdef FRACNET_ACC_RELU_EN
    if (r < 0) r = 0;
    sat = hi;
`endif
  endfunction
  task automatic send(input longint d, input bit last, input int sh);
    int n = 0;
    bus.prod_tdata = 44'(d);
    bus.prod_tlast = last;
    bus.cfg_shift = 6'(sh);
    bus.prod_tvalid = 1'b1;
    while (!bus.prod_tready && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 0, 1);
    @(posedge ap_clk);
    #1;
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast = 1'b0;
  endtask
  task automatic get_out(input int stall, output longint d, output bit sat);
    int n = 0;
    longint d0;
    bus.out_tready = 1'b0;
    while (!bus.out_tvalid && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 50) check("out_timeout", 0, 1);
    d0 = bus.out_tdata;
    repeat (stall) @(negedge ap_clk);
    if (stall > 0) check("out_hold_stable", bus.out_tdata, d0);
    d = bus.out_tdata;
    sat = bus.out_sat;
    bus.out_tready = 1'b1;
    @(posedge ap_clk);
    #1;
    bus.out_tready = 1'b0;
  endtask
  task automatic run_group(input string name, input int sh, input int stall);
    longint acc = 0, r, d;
    bit s, ds;
    foreach (beats[i]) begin
      acc += beats[i];
      send(beats[i], i == beats.size() - 1, i == 0 ? sh : int'($urandom_range(0, 63)));
    end
    get_out(stall, d, ds);
    model(acc, sh, r, s);
    check({name, "_data"}, d, r);
    check({name, "_sat"}, longint'(ds), longint'(s));
  endtask
  task automatic pulse_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    check("rst_ready", bus.prod_tready, 0);
    check("rst_valid", bus.out_tvalid, 0);
    check("rst_ovf", bus.acc_ovf, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask
  initial begin
    longint d, e;
    bit s, es;
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast = 1'b0;
    bus.prod_tdata = '0;
    bus.cfg_shift = '0;
    bus.out_tready = 1'b0;
    vecs = '{
      '{769, 4, 48, 0}, '{-24, 4, -1, 0}, '{longint'(1) <<< 30, 8, 32767, 1},
      '{-(longint'(1) <<< 30), 8, -32768, 1}, '{0, 0, 0, 0}, '{32767, 0, 32767, 0},
      '{32768, 0, 32767, 1}, '{-32768, 0, -32768, 0}, '{-32769, 0, -32768, 1},
      '{24, 4, 2, 0}, '{-8, 4, 0, 0}, '{1, 1, 1, 0}, '{-5, 63, -1, 0}, '{-5, 52, 0, 0},
      '{12345, 53, 0, 0}
    };
    repeat (3) @(negedge ap_clk);
    check("reset_ready", bus.prod_tready, 0);
    check("reset_valid", bus.out_tvalid, 0);
    check("reset_data", bus.out_tdata, 0);
    check("reset_sat", bus.out_sat, 0);
    check("reset_ovf", bus.acc_ovf, 0);
    ap_rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", bus.prod_tready, 0);
    @(posedge ap_clk);
    #1;
    check("ready_after_first_edge", bus.prod_tready, 1);
    bus.out_tready = 1'b1;
    send(100, 0, 0);
    send(200, 0, 0);
    send(-50, 1, 0);
    check("lat_valid_k", bus.out_tvalid, 0);
    @(posedge ap_clk);
    #1;
    check("lat_valid_k1", bus.out_tvalid, 1);
    check("sum3_data", bus.out_tdata, 250);
    check("sum3_sat", bus.out_sat, 0);
    @(posedge ap_clk);
    #1;
    check("valid_one_cycle", bus.out_tvalid, 0);
    check("ready_after_out", bus.prod_tready, 1);
    bus.out_tready = 1'b0;
    foreach (vecs[i]) begin
      send(vecs[i].d, 1, vecs[i].sh);
      get_out(0, d, s);
      e = vecs[i].exp;
      es = vecs[i].sat;
      relu_adj(e, es);
      check($sformatf("vec%0d_data", i), d, e);
      check($sformatf("vec%0d_sat", i), longint'(s), longint'(es));
    end
    send(769, 0, 4);
    send(0, 1, 0);
    get_out(0, d, s);
    check("shift_latched_first_beat", d, 48);
    send(30, 0, 0);
    send(40, 1, 0);
    bus.prod_tdata = 44'(5);
    bus.prod_tlast = 1'b1;
    bus.cfg_shift = '0;
    bus.prod_tvalid = 1'b1;
    @(posedge ap_clk);
    #1;
    check("stall_valid_up", bus.out_tvalid, 1);
    repeat (5) begin
      @(negedge ap_clk);
      check("stall_ready_low", bus.prod_tready, 0);
      check("stall_valid_held", bus.out_tvalid, 1);
      check("stall_data_stable", bus.out_tdata, 70);
    end
    bus.out_tready = 1'b1;
    @(posedge ap_clk);
    #1;
    bus.out_tready = 1'b0;
    check("stall_release_valid", bus.out_tvalid, 0);
    check("stall_release_ready", bus.prod_tready, 1);
    @(posedge ap_clk);
    #1;
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast = 1'b0;
    check("held_beat_accepted", bus.prod_tready, 0);
    get_out(0, d, s);
    check("held_beat_result", d, 5);
    for (int i = 0; i < 256; i++) send(1, 0, 0);
    check("ovf_at_256", bus.acc_ovf, 0);
    send(1, 0, 0);
    check("ovf_at_257", bus.acc_ovf, 1);
    send(1, 1, 0);
    get_out(0, d, s);
    check("ovf_group_data", d, 258);
    beats = '{3, 4};
    run_group("post_ovf", 0, 0);
    check("ovf_sticky", bus.acc_ovf, 1);
    pulse_reset();
    check("ovf_cleared", bus.acc_ovf, 0);
    send(1000, 0, 0);
    send(2000, 0, 0);
    pulse_reset();
    repeat (4) @(negedge ap_clk);
    check("no_out_after_reset", bus.out_tvalid, 0);
    send(7, 0, 0);
    send(8, 1, 0);
    get_out(0, d, s);
    check("fresh_group", d, 15);
    for (int g = 0; g < 40; g++) begin
      beats.delete();
      for (int b = 0; b < int'($urandom_range(1, 6)); b++) begin
        longint v;
        int w;
        v = {$urandom, $urandom};
        w = int'($urandom_range(1, 44));
        beats.push_back((v <<< (64 - w)) >>> (64 - w));
      end
      run_group($sformatf("rand%0d", g), int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
